// File: rtl/alu_seq_ctrl_if.sv
// Strobe/handshake bundle between alu_seq_ctrl (master) and the datapath side (slave).
// Widths follow REG_BITS / OP_WIDTH / CNT_WIDTH of the sequencer instance.
interface alu_seq_ctrl_if #(
    parameter int REG_BITS  = 4,
    parameter int OP_WIDTH  = 5,
    parameter int CNT_WIDTH = 16
);
    localparam int NUM_REGS = 2 ** REG_BITS;

    logic                 run;
    logic [31:0]          ir;
    logic                 mem_ready;
    logic                 PCout;
    logic                 MARin;
    logic                 IncPC;
    logic                 PCin;
    logic                 Read;
    logic                 MDRin;
    logic                 MDRout;
    logic                 IRin;
    logic                 Yin;
    logic                 ZLowin;
    logic                 ZHighin;
    logic                 ZLowout;
    logic                 ZHighout;
    logic                 HIin;
    logic                 LOin;
    logic [NUM_REGS-1:0]  Rin;
    logic [NUM_REGS-1:0]  Rout;
    logic [OP_WIDTH-1:0]  OP;
    logic                 done;
    logic                 err;
    logic [CNT_WIDTH-1:0] instr_count;

    modport master (
        input  run, ir, mem_ready,
        output PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
               ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin,
               Rin, Rout, OP, done, err, instr_count
    );

    modport slave (
        output run, ir, mem_ready,
        input  PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
               ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin,
               Rin, Rout, OP, done, err, instr_count
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Fetch/execute strobe sequencer for the bus datapath (T0..T6, HALT on illegal opcode).
// Define ALU_SEQ_MULDIV_EN to enable MUL/DIV sequencing through T5/T6.
module alu_seq_ctrl #(
    parameter int REG_BITS  = 4,
    parameter int OP_WIDTH  = 5,
    parameter int CNT_WIDTH = 16
) (
    input  logic           Clock,
    input  logic           Clear,
    alu_seq_ctrl_if.master bus
);
    localparam int NUM_REGS = 2 ** REG_BITS;
    localparam int RA_MSB   = 31 - OP_WIDTH;
    localparam int RB_MSB   = RA_MSB - REG_BITS;
    localparam int RC_MSB   = RB_MSB - REG_BITS;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
`ifdef ALU_SEQ_MULDIV_EN
        S_T6   = 4'd7,
`endif
        S_HALT = 4'd8
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic                 err_r;
    logic [CNT_WIDTH-1:0] cnt_r;

    logic [OP_WIDTH-1:0]  opc_s;
    logic [REG_BITS-1:0]  ra_s;
    logic [REG_BITS-1:0]  rb_s;
    logic [REG_BITS-1:0]  rc_s;
    logic [31:0]          opc_ext_s;
    logic                 is_bin_s;
    logic                 is_un_s;
    logic                 is_md_s;
    logic                 is_ill_s;
    logic                 unused_ir_s;

    logic pc_out_s, mar_in_s, inc_pc_s, pc_in_s, read_s, mdr_in_s, mdr_out_s, ir_in_s;
    logic y_in_s, zlow_in_s, zhigh_in_s, zlow_out_s, zhigh_out_s, hi_in_s, lo_in_s;
    logic done_s, err_s;
    logic [NUM_REGS-1:0] rin_s;
    logic [NUM_REGS-1:0] rout_s;
    logic [OP_WIDTH-1:0] op_s;

    function automatic logic [NUM_REGS-1:0] reg_sel(input logic [REG_BITS-1:0] idx);
        reg_sel = NUM_REGS'(1'b1) << idx;
    endfunction

    // After the done state the sequencer either refetches or parks in IDLE.
    function automatic state_t after_done(input logic run_v);
        if (run_v) begin
            after_done = S_T0;
        end else begin
            after_done = S_IDLE;
        end
    endfunction

    assign opc_s       = bus.ir[31 -: OP_WIDTH];
    assign ra_s        = bus.ir[RA_MSB -: REG_BITS];
    assign rb_s        = bus.ir[RB_MSB -: REG_BITS];
    assign rc_s        = bus.ir[RC_MSB -: REG_BITS];
    assign opc_ext_s   = 32'(opc_s);
    assign unused_ir_s = ^bus.ir;

    assign is_bin_s = (opc_ext_s <= 32'h0000_000E);
    assign is_un_s  = (opc_ext_s == 32'h0000_0011) || (opc_ext_s == 32'h0000_0012);
`ifdef ALU_SEQ_MULDIV_EN
    assign is_md_s  = (opc_ext_s == 32'h0000_000F) || (opc_ext_s == 32'h0000_0010);
`else
    assign is_md_s  = 1'b0;
`endif
    assign is_ill_s = !(is_bin_s || is_un_s || is_md_s);

    // Next-state and strobe decode from the registered state and the IR fields.
    always_comb begin
        state_nxt_s = state_r;
        pc_out_s    = 1'b0;
        mar_in_s    = 1'b0;
        inc_pc_s    = 1'b0;
        pc_in_s     = 1'b0;
        read_s      = 1'b0;
        mdr_in_s    = 1'b0;
        mdr_out_s   = 1'b0;
        ir_in_s     = 1'b0;
        y_in_s      = 1'b0;
        zlow_in_s   = 1'b0;
        zhigh_in_s  = 1'b0;
        zlow_out_s  = 1'b0;
        zhigh_out_s = 1'b0;
        hi_in_s     = 1'b0;
        lo_in_s     = 1'b0;
        done_s      = 1'b0;
        err_s       = err_r;
        rin_s       = {NUM_REGS{1'b0}};
        rout_s      = {NUM_REGS{1'b0}};
        op_s        = {OP_WIDTH{1'b0}};
        case (state_r)
            S_IDLE: begin
                if (bus.run) begin
                    state_nxt_s = S_T0;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_T0: begin
                pc_out_s    = 1'b1;
                mar_in_s    = 1'b1;
                inc_pc_s    = 1'b1;
                zlow_in_s   = 1'b1;
                zhigh_in_s  = 1'b1;
                state_nxt_s = S_T1;
            end
            S_T1: begin
                zlow_out_s = 1'b1;
                pc_in_s    = 1'b1;
                read_s     = 1'b1;
                mdr_in_s   = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt_s = S_T2;
                end else begin
                    state_nxt_s = S_T1;
                end
            end
            S_T2: begin
                mdr_out_s   = 1'b1;
                ir_in_s     = 1'b1;
                state_nxt_s = S_T3;
            end
            S_T3: begin
                if (is_bin_s) begin
                    rout_s      = reg_sel(rb_s);
                    y_in_s      = 1'b1;
                    state_nxt_s = S_T4;
                end else if (is_un_s) begin
                    rout_s      = reg_sel(rb_s);
                    zlow_in_s   = 1'b1;
                    zhigh_in_s  = 1'b1;
                    op_s        = opc_s;
                    state_nxt_s = S_T4;
                end else if (is_md_s) begin
                    rout_s      = reg_sel(ra_s);
                    y_in_s      = 1'b1;
                    state_nxt_s = S_T4;
                end else begin
                    err_s       = 1'b1;
                    state_nxt_s = S_HALT;
                end
            end
            S_T4: begin
                if (is_bin_s || is_md_s) begin
                    rout_s      = is_bin_s ? reg_sel(rc_s) : reg_sel(rb_s);
                    zlow_in_s   = 1'b1;
                    zhigh_in_s  = 1'b1;
                    op_s        = opc_s;
                    state_nxt_s = S_T5;
                end else if (is_un_s) begin
                    zlow_out_s  = 1'b1;
                    rin_s       = reg_sel(ra_s);
                    done_s      = 1'b1;
                    state_nxt_s = after_done(bus.run);
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_T5: begin
                if (is_bin_s) begin
                    zlow_out_s  = 1'b1;
                    rin_s       = reg_sel(ra_s);
                    done_s      = 1'b1;
                    state_nxt_s = after_done(bus.run);
`ifdef ALU_SEQ_MULDIV_EN
                end else if (is_md_s) begin
                    zlow_out_s  = 1'b1;
                    lo_in_s     = 1'b1;
                    state_nxt_s = S_T6;
`endif
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
`ifdef ALU_SEQ_MULDIV_EN
            S_T6: begin
                zhigh_out_s = 1'b1;
                hi_in_s     = 1'b1;
                done_s      = 1'b1;
                state_nxt_s = after_done(bus.run);
            end
`endif
            S_HALT: begin
                state_nxt_s = S_HALT;
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register, sticky illegal-opcode flag and retired-instruction counter.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_r <= S_IDLE;
            err_r   <= 1'b0;
            cnt_r   <= {CNT_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s == S_HALT) begin
                err_r <= 1'b1;
            end
            if (done_s) begin
                cnt_r <= cnt_r + CNT_WIDTH'(1'b1);
            end
        end
    end

    assign bus.PCout       = pc_out_s;
    assign bus.MARin       = mar_in_s;
    assign bus.IncPC       = inc_pc_s;
    assign bus.PCin        = pc_in_s;
    assign bus.Read        = read_s;
    assign bus.MDRin       = mdr_in_s;
    assign bus.MDRout      = mdr_out_s;
    assign bus.IRin        = ir_in_s;
    assign bus.Yin         = y_in_s;
    assign bus.ZLowin      = zlow_in_s;
    assign bus.ZHighin     = zhigh_in_s;
    assign bus.ZLowout     = zlow_out_s;
    assign bus.ZHighout    = zhigh_out_s;
    assign bus.HIin        = hi_in_s;
    assign bus.LOin        = lo_in_s;
    assign bus.Rin         = rin_s;
    assign bus.Rout        = rout_s;
    assign bus.OP          = op_s;
    assign bus.done        = done_s;
    assign bus.err         = err_s;
    assign bus.instr_count = cnt_r;
endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Synthesizable control sequencer for the bus datapath. It generates the fetch strobes (T0–T2) and the execute strobes (T3–T6) for register-register ALU, unary and multiply/divide instructions. Register count, register-field width, opcode width and counter width are parameters. A memory-ready handshake on the fetch read replaces hand-timed strobe waveforms. The block sits beside `datapath`, drives its strobe ports, and reads back the IR contents.

## Interface
- `REG_BITS`, 4, register-field width; `NUM_REGS = 2**REG_BITS`, valid range 1..9.
- `OP_WIDTH`, 5, opcode field width, IR[31:32-OP_WIDTH].
- `CNT_WIDTH`, 16, retired-instruction counter width.

Ports:
- `Clock`  in  1  system clock, rising edge.
- `Clear`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; start and continue fetching.
- `ir`  in  32  current IR register contents.
- `mem_ready`  in  1  memory read data valid this cycle.
- `PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin`  out  1 each  datapath strobes.
- `Rin`  out  NUM_REGS  one-hot register load.
- `Rout`  out  NUM_REGS  one-hot register drive.
- `OP`  out  OP_WIDTH  ALU operation.
- `done`  out  1  one-cycle pulse on the last execute state.
- `err`  out  1  sticky illegal-opcode flag.
- `instr_count`  out  CNT_WIDTH  retired instructions, wraps.

## Operation
IR field decode:
- `opc` = ir[31:32-OP_WIDTH]
- `Ra` = next REG_BITS bits below `opc`
- `Rb` = next REG_BITS bits below `Ra`
- `Rc` = next REG_BITS bits below `Rb`

The IR is loaded at the end of T2, so decode is valid from T3.

States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT.

Fetch:
- T0: `PCout`, `MARin`, `IncPC`, `ZLowin`, `ZHighin`.
- T1: `ZLowout`, `PCin`, `Read`, `MDRin`. The state holds while `mem_ready`=0; the repeated PCin is idempotent.
- T2: `MDRout`, `IRin`.

Execute by opcode class. `OP` = `opc` whenever `ZLowin` is asserted in execute; otherwise `OP` = 0.
- Binary, opc 0x00–0x0E:
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], ZLowin, ZHighin.
  - T5: ZLowout, Rin[Ra], done.
- Unary, NEG 0x11 / NOT 0x12:
  - T3: Rout[Rb], ZLowin, ZHighin.
  - T4: ZLowout, Rin[Ra], done.
- MUL 0x0F / DIV 0x10:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], ZLowin, ZHighin.
  - T5: ZLowout, LOin.
  - T6: ZHighout, HIin, done.
- opc ≥ 0x13: at T3 go to HALT. `err`=1, all strobes 0. Only `Clear` exits HALT.

Transitions:
- IDLE→T0 when `run`=1.
- After the `done` state: →T0 if `run`=1, else →IDLE.
- `run` deasserted mid-instruction: the instruction completes, then IDLE.

Counter:
- `instr_count` increments on each `done` cycle.
- All-ones wraps to 0.

## Timing
- Strobes are combinational decodes of the registered state and `ir`. They are glitch-free relative to the `Clock` edge because `ir` changes only at the end of T2.
- Latency from `run` at IDLE to `done`, with `mem_ready` tied high:
  - binary: 6 cycles
  - unary: 5 cycles
  - MUL/DIV: 7 cycles
- Each cycle of `mem_ready` low in T1 adds one cycle.
- `mem_ready` high on the first T1 cycle: no wait.
- `mem_ready` outside T1 is ignored.
- Reset (`Clear`=0), asynchronous:
  - state = IDLE
  - every strobe, `Rin`, `Rout`, `OP`, `done` and `err` = 0
  - `instr_count` = 0
- `Clear` asserted mid-instruction aborts immediately. No partial write-back strobe is issued after the reset edge.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: MUL/DIV sequencing through T5/T6 as above.
- Not defined:
  - opcodes 0x0F/0x10 are illegal (HALT, `err`=1);
  - T6 is removed;
  - `HIin`, `LOin` and `ZHighout` are tied to 0.

## Test plan
- Binary AND: `ir`=0x28918000, `run`=1, `mem_ready`=1.
  - T3: `Rout`=0x0004, `Yin`=1.
  - T4: `Rout`=0x0008, `OP`=0x05, `ZLowin`=`ZHighin`=1.
  - T5: `ZLowout`=1, `Rin`=0x0002, `done`=1.
  - 6 cycles total; `instr_count`=1.
- Fetch wait: `mem_ready` low for 3 cycles in T1.
  - T1 held 4 cycles with `Read`=`MDRin`=`PCin`=1 throughout.
  - T2 follows on the cycle after `mem_ready`=1.
- MUL (macro defined): `ir`=0x7A280000.
  - T3: `Rout`=0x0010, `Yin`=1.
  - T4: `Rout`=0x0020, `OP`=0x0F.
  - T5: `ZLowout`=1, `LOin`=1.
  - T6: `ZHighout`=1, `HIin`=1, `done`=1.
  - Without the macro: `err`=1 at T3.
- NOT: `ir`=0x93380000.
  - T3: `Rout`=0x0080, `OP`=0x12, `ZLowin`=1.
  - T4: `ZLowout`=1, `Rin`=0x0040, `done`=1.
- Illegal then reset: `ir`=0x98000000.
  - HALT with `err`=1; `run` is ignored for 10 cycles.
  - `Clear`=0 pulse → IDLE, `err`=0, `instr_count`=0.
- Reset mid-T4 of the AND instruction.
  - All strobes drop within the same cycle; no `Rin` pulse.
  - After `Clear` rises with `run`=1, fetch restarts at T0.
